player_link_rx: RTL and testbench

Byte-level receive deframer for the two-board co-op link. It consumes bytes from the UART receiver, hunts for a sync byte, assembles an 11-byte state packet and verifies its checksum. It then drives the `player_2_*` and `boss_out_*` inputs of `top_vga` plus `player_2_data_valid`. A link watchdog drops `player_2_data_valid` when the remote board goes silent.

---
 rtl/player_link_rx.sv | 185 ++++++++++++++++++
 tb/tb_player_link_rx.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/player_link_rx.sv
// player_link_rx: receive deframer for the co-op link.
// It hunts for the 0xA5 sync byte and assembles the 11-byte state packet.
// It verifies the XOR checksum and publishes the fields on a good packet.
// A watchdog drops player_2_data_valid when the remote side goes quiet.
module player_link_rx #(
    parameter int BYTE_TIMEOUT = 20000,
    parameter int LINK_TIMEOUT = 4000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [11:0] player_2_x,
    output logic [11:0] player_2_y,
    output logic [3:0]  player_2_hp,
    output logic [3:0]  player_2_aggro,
    output logic        player_2_flip_h,
    output logic [1:0]  player_2_class,
    output logic [11:0] boss_out_x,
    output logic [11:0] boss_out_y,
    output logic [6:0]  boss_out_hp,
    output logic        player_2_data_valid,
    output logic        frame_ok,
    output logic        frame_err
);

    localparam int IW = (BYTE_TIMEOUT > 2) ? $clog2(BYTE_TIMEOUT) : 1;
    localparam int LW = (LINK_TIMEOUT > 2) ? $clog2(LINK_TIMEOUT) : 1;
    localparam logic [IW-1:0] IDLE_MAX = IW'(BYTE_TIMEOUT - 1);
    localparam logic [LW-1:0] LINK_MAX = LW'(LINK_TIMEOUT - 1);
    localparam logic [7:0]    SYNC     = 8'hA5;

    typedef enum logic [1:0] {HUNT, PAYLOAD, CHECK} state_t;

    state_t        state_q, state_d;
    logic [3:0]    idx_q, idx_d;
    logic [7:0]    acc_q, acc_d;
    logic [IW-1:0] idle_q, idle_d;
    logic [LW-1:0] link_q, link_d;
    logic [7:0]    shadow_q [9];
    logic [7:0]    shadow_d [9];
    logic [11:0]   x_q, x_d, y_q, y_d, bx_q, bx_d, by_q, by_d;
    logic [3:0]    hp_q, hp_d, aggro_q, aggro_d;
    logic          flip_q, flip_d;
    logic [1:0]    class_q, class_d;
    logic [6:0]    bhp_q, bhp_d;
    logic          valid_q, valid_d, ok_q, ok_d, err_q, err_d;

    // Next-state logic: deframer FSM, idle timeout and link watchdog.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        acc_d    = acc_q;
        idle_d   = idle_q;
        shadow_d = shadow_q;
        x_d      = x_q;
        y_d      = y_q;
        hp_d     = hp_q;
        aggro_d  = aggro_q;
        flip_d   = flip_q;
        class_d  = class_q;
        bx_d     = bx_q;
        by_d     = by_q;
        bhp_d    = bhp_q;
        ok_d     = 1'b0;
        err_d    = 1'b0;
        link_d   = (link_q == LINK_MAX) ? link_q : link_q + 1'b1;
        valid_d  = valid_q && (link_q != LINK_MAX);

        case (state_q)
            HUNT: begin
                if (rx_valid && rx_data == SYNC) begin
                    acc_d   = 8'h00;
                    idx_d   = 4'd0;
                    idle_d  = '0;
                    state_d = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (rx_valid) begin
                    shadow_d[idx_q] = rx_data;
                    acc_d  = acc_q ^ rx_data;
                    idle_d = '0;
                    if (idx_q == 4'd8) begin
                        state_d = CHECK;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end else if (idle_q == IDLE_MAX) begin
                    err_d   = 1'b1;
                    idle_d  = '0;
                    state_d = HUNT;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
            end
            CHECK: begin
                if (rx_valid) begin
                    idle_d  = '0;
                    state_d = HUNT;
                    if (rx_data == acc_q) begin
                        x_d     = {shadow_q[0], shadow_q[1][7:4]};
                        y_d     = {shadow_q[1][3:0], shadow_q[2]};
                        hp_d    = shadow_q[3][7:4];
                        aggro_d = shadow_q[3][3:0];
                        flip_d  = shadow_q[4][7];
                        class_d = shadow_q[4][6:5];
                        bx_d    = {shadow_q[5], shadow_q[6][7:4]};
                        by_d    = {shadow_q[6][3:0], shadow_q[7]};
                        bhp_d   = shadow_q[8][6:0];
                        ok_d    = 1'b1;
                        link_d  = '0;
                        valid_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (idle_q == IDLE_MAX) begin
                    err_d   = 1'b1;
                    idle_d  = '0;
                    state_d = HUNT;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
            end
            default: state_d = HUNT;
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= HUNT;
            idx_q   <= 4'd0;
            acc_q   <= 8'h00;
            idle_q  <= '0;
            link_q  <= '0;
            for (int i = 0; i < 9; i++) shadow_q[i] <= 8'h00;
            x_q     <= '0;
            y_q     <= '0;
            hp_q    <= '0;
            aggro_q <= '0;
            flip_q  <= 1'b0;
            class_q <= '0;
            bx_q    <= '0;
            by_q    <= '0;
            bhp_q   <= '0;
            valid_q <= 1'b0;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            acc_q    <= acc_d;
            idle_q   <= idle_d;
            link_q   <= link_d;
            shadow_q <= shadow_d;
            x_q      <= x_d;
            y_q      <= y_d;
            hp_q     <= hp_d;
            aggro_q  <= aggro_d;
            flip_q   <= flip_d;
            class_q  <= class_d;
            bx_q     <= bx_d;
            by_q     <= by_d;
            bhp_q    <= bhp_d;
            valid_q  <= valid_d;
            ok_q     <= ok_d;
            err_q    <= err_d;
        end
    end

    assign player_2_x          = x_q;
    assign player_2_y          = y_q;
    assign player_2_hp         = hp_q;
    assign player_2_aggro      = aggro_q;
    assign player_2_flip_h     = flip_q;
    assign player_2_class      = class_q;
    assign boss_out_x          = bx_q;
    assign boss_out_y          = by_q;
    assign boss_out_hp         = bhp_q;
    assign player_2_data_valid = valid_q;
    assign frame_ok            = ok_q;
    assign frame_err           = err_q;

endmodule

// File: tb/tb_player_link_rx.sv
// tb_player_link_rx: directed and randomized packets for player_link_rx.
// Expected fields come from a packet-level model of the link format.
module tb_player_link_rx;

    localparam int BT = 50;
    localparam int LT = 1000;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [11:0] p2_x, p2_y, b_x, b_y;
    logic [3:0]  p2_hp, p2_aggro;
    logic        p2_flip;
    logic [1:0]  p2_class;
    logic [6:0]  b_hp;
    logic        p2_valid, frame_ok, frame_err;

    always #5 clk = ~clk;

    player_link_rx #(.BYTE_TIMEOUT(BT), .LINK_TIMEOUT(LT)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .player_2_x(p2_x), .player_2_y(p2_y), .player_2_hp(p2_hp),
        .player_2_aggro(p2_aggro), .player_2_flip_h(p2_flip),
        .player_2_class(p2_class), .boss_out_x(b_x), .boss_out_y(b_y),
        .boss_out_hp(b_hp), .player_2_data_valid(p2_valid),
        .frame_ok(frame_ok), .frame_err(frame_err)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int ok_times[$];

    logic [7:0]  pkt [11];
    logic [11:0] ex, ey, ebx, eby;
    logic [3:0]  ehp, eag;
    logic        efl;
    logic [1:0]  ecl;
    logic [6:0]  ebhp;

    // Records the cycle of every frame_ok pulse, sampled on the falling edge.
    always @(negedge clk) begin
        cyc++;
        if (frame_ok === 1'b1) ok_times.push_back(cyc);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input logic eok, input logic eerr, input logic evalid);
        check({tag, ".x"}, 32'(p2_x), 32'(ex));
        check({tag, ".y"}, 32'(p2_y), 32'(ey));
        check({tag, ".hp"}, 32'(p2_hp), 32'(ehp));
        check({tag, ".aggro"}, 32'(p2_aggro), 32'(eag));
        check({tag, ".flip"}, 32'(p2_flip), 32'(efl));
        check({tag, ".class"}, 32'(p2_class), 32'(ecl));
        check({tag, ".boss_x"}, 32'(b_x), 32'(ebx));
        check({tag, ".boss_y"}, 32'(b_y), 32'(eby));
        check({tag, ".boss_hp"}, 32'(b_hp), 32'(ebhp));
        check({tag, ".frame_ok"}, 32'(frame_ok), 32'(eok));
        check({tag, ".frame_err"}, 32'(frame_err), 32'(eerr));
        check({tag, ".valid"}, 32'(p2_valid), 32'(evalid));
    endtask

    // Packet model: serialises fields and appends the XOR of B1..B9.
    task automatic make_packet(input logic [11:0] x, input logic [11:0] y,
                               input logic [3:0] hp, input logic [3:0] ag,
                               input logic fl, input logic [1:0] cl,
                               input logic [11:0] bx, input logic [11:0] by,
                               input logic [6:0] bhp, input logic [4:0] r5, input logic r9);
        pkt[0]  = 8'hA5;
        pkt[1]  = x[11:4];
        pkt[2]  = {x[3:0], y[11:8]};
        pkt[3]  = y[7:0];
        pkt[4]  = {hp, ag};
        pkt[5]  = {fl, cl, r5};
        pkt[6]  = bx[11:4];
        pkt[7]  = {bx[3:0], by[11:8]};
        pkt[8]  = by[7:0];
        pkt[9]  = {r9, bhp};
        pkt[10] = 8'h00;
        for (int i = 1; i < 10; i++) pkt[10] = pkt[10] ^ pkt[i];
    endtask

    task automatic set_expected(input logic [11:0] x, input logic [11:0] y,
                                input logic [3:0] hp, input logic [3:0] ag,
                                input logic fl, input logic [1:0] cl,
                                input logic [11:0] bx, input logic [11:0] by,
                                input logic [6:0] bhp);
        ex = x; ey = y; ehp = hp; eag = ag; efl = fl; ecl = cl;
        ebx = bx; eby = by; ebhp = bhp;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    // Sends the 11 bytes of pkt with up to gap_max idle cycles between bytes.
    task automatic applyStimulus(input int gap_max);
        for (int i = 0; i < 11; i++) begin
            send_byte(pkt[i]);
            if (i < 10 && gap_max > 0) repeat ($urandom_range(0, gap_max)) @(negedge clk);
        end
    endtask

    logic [7:0]  spec_bytes [11];
    logic [11:0] r_x, r_y, r_bx, r_by;
    logic [3:0]  r_hp, r_ag;
    logic        r_fl, r_r9;
    logic [1:0]  r_cl;
    logic [6:0]  r_bhp;
    logic [4:0]  r_r5;
    logic [7:0]  g;
    logic        corrupt;

    task automatic randomize_fields();
        r_x  = 12'($urandom); r_y  = 12'($urandom);
        r_hp = 4'($urandom);  r_ag = 4'($urandom);
        r_fl = 1'($urandom);  r_cl = 2'($urandom);
        r_bx = 12'($urandom); r_by = 12'($urandom);
        r_bhp = 7'($urandom); r_r5 = 5'($urandom); r_r9 = 1'($urandom);
    endtask

    initial begin
        spec_bytes = '{8'hA5, 8'h12, 8'h32, 8'hA0, 8'h53, 8'hC0,
                       8'h30, 8'h01, 8'hF4, 8'h64, 8'hB2};
        rst = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        set_expected(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        checkOutput("reset", 0, 0, 0);
        rst = 1'b1;
        @(negedge clk);

        // Bad checksum first: outputs must stay at reset values.
        pkt = spec_bytes;
        pkt[10] = 8'hB3;
        applyStimulus(0);
        checkOutput("bad_sum", 0, 1, 0);
        @(negedge clk);
        check("bad_sum.err_pulse_end", 32'(frame_err), 32'd0);

        // Reference good packet from literal bytes.
        pkt = spec_bytes;
        applyStimulus(0);
        set_expected(12'h123, 12'h2A0, 4'd5, 4'd3, 1'b1, 2'd2, 12'h300, 12'h1F4, 7'd100);
        checkOutput("good", 1, 0, 1);
        @(negedge clk);
        check("good.ok_pulse_end", 32'(frame_ok), 32'd0);

        // Leading garbage plus a 0xA5 inside the payload.
        ok_times.delete();
        send_byte(8'h00); send_byte(8'hFF); send_byte(8'h7E);
        make_packet(12'hABC, 12'h2A5, 4'd9, 4'd1, 1'b0, 2'd1, 12'h456, 12'h789, 7'd42, 5'd0, 1'b0);
        applyStimulus(2);
        set_expected(12'hABC, 12'h2A5, 4'd9, 4'd1, 1'b0, 2'd1, 12'h456, 12'h789, 7'd42);
        checkOutput("embedded_sync", 1, 0, 1);
        check("embedded_sync.y_low", 32'(p2_y[7:0]), 32'hA5);
        repeat (2) @(negedge clk);
        check("embedded_sync.ok_count", 32'(ok_times.size()), 32'd1);

        // Byte timeout after a partial packet.
        send_byte(8'hA5); send_byte(8'h12); send_byte(8'h32);
        repeat (BT - 1) @(negedge clk);
        check("timeout.before", 32'(frame_err), 32'd0);
        @(negedge clk);
        check("timeout.err", 32'(frame_err), 32'd1);
        @(negedge clk);
        check("timeout.after", 32'(frame_err), 32'd0);
        make_packet(12'h001, 12'hFFF, 4'd15, 4'd0, 1'b1, 2'd3, 12'h800, 12'h001, 7'd127, 5'h1F, 1'b1);
        applyStimulus(0);
        set_expected(12'h001, 12'hFFF, 4'd15, 4'd0, 1'b1, 2'd3, 12'h800, 12'h001, 7'd127);
        checkOutput("after_timeout", 1, 0, 1);

        // Link loss: valid stays high LT cycles, fields hold afterwards.
        repeat (LT - 1) @(negedge clk);
        check("link.still_valid", 32'(p2_valid), 32'd1);
        @(negedge clk);
        checkOutput("link.dropped", 0, 0, 0);
        make_packet(12'h321, 12'h654, 4'd2, 4'd7, 1'b0, 2'd0, 12'h0AA, 12'h055, 7'd5, 5'd3, 1'b0);
        applyStimulus(1);
        set_expected(12'h321, 12'h654, 4'd2, 4'd7, 1'b0, 2'd0, 12'h0AA, 12'h055, 7'd5);
        checkOutput("link.restored", 1, 0, 1);

        // Reset mid-packet, then two back-to-back packets.
        make_packet(12'h777, 12'h888, 4'd1, 4'd1, 1'b1, 2'd1, 12'h111, 12'h222, 7'd9, 5'd0, 1'b0);
        for (int i = 0; i < 6; i++) send_byte(pkt[i]);
        rst = 1'b0;
        @(negedge clk);
        set_expected(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("mid_reset", 0, 0, 0);
        rst = 1'b1;
        @(negedge clk);
        ok_times.delete();
        make_packet(12'h0F0, 12'h00F, 4'd3, 4'd4, 1'b0, 2'd2, 12'h123, 12'h456, 7'd64, 5'd0, 1'b0);
        applyStimulus(0);
        make_packet(12'hF0F, 12'hA5A, 4'd6, 4'd8, 1'b1, 2'd1, 12'hA5A, 12'h5A5, 7'd33, 5'd7, 1'b1);
        applyStimulus(0);
        set_expected(12'hF0F, 12'hA5A, 4'd6, 4'd8, 1'b1, 2'd1, 12'hA5A, 12'h5A5, 7'd33);
        checkOutput("back_to_back", 1, 0, 1);
        repeat (2) @(negedge clk);
        check("back_to_back.count", 32'(ok_times.size()), 32'd2);
        if (ok_times.size() == 2)
            check("back_to_back.spacing", 32'(ok_times[1] - ok_times[0]), 32'd11);

        // Randomized packets, some with corrupted checksums.
        for (int n = 0; n < 25; n++) begin
            repeat ($urandom_range(0, 2)) begin
                g = 8'($urandom);
                if (g == 8'hA5) g = 8'h00;
                send_byte(g);
            end
            randomize_fields();
            make_packet(r_x, r_y, r_hp, r_ag, r_fl, r_cl, r_bx, r_by, r_bhp, r_r5, r_r9);
            corrupt = ($urandom_range(0, 3) == 0);
            if (corrupt) pkt[10] = pkt[10] ^ 8'(1 << $urandom_range(0, 7));
            applyStimulus(3);
            if (!corrupt) set_expected(r_x, r_y, r_hp, r_ag, r_fl, r_cl, r_bx, r_by, r_bhp);
            checkOutput($sformatf("rand%0d", n), !corrupt, corrupt, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
